fetch_controller: RTL and testbench

Sequencing controller for the fetch stage. It drives the program counter enable, PC source select and branch target, and the IF/ID and ID/EX pipeline-register write/flush controls. It arbitrates between post-reset boot hold, branch/jump redirects from EX, load-use stalls from the hazard unit, and an external halt request. A redirect that arrives during halt is held and replayed when the halt releases. It sits between the hazard/branch logic and `fetch_stage`, and feeds that stage's `IF_pc_en_i`/`IF_PCSrc_i`/`IF_branch_target_addr_i`.

---
 rtl/fetch_controller_if.sv | 38 +++
 rtl/fetch_controller.sv | 138 +++++++++++++
 tb/tb_fetch_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Control bundle between the hazard/branch logic and the fetch controller.
// The controller side uses the slave modport; the requester/observer side uses master.
interface fetch_controller_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall_req_i;
  logic                  redirect_i;
  logic [DATA_WIDTH-1:0] redirect_addr_i;
  logic                  halt_i;

  logic                  pc_en_o;
  logic                  PCSrc_o;
  logic [DATA_WIDTH-1:0] branch_target_addr_o;
  logic                  IF_ID_write_o;
  logic                  IF_ID_flush_o;
  logic                  ID_EX_flush_o;
  logic                  fetch_valid_o;
  logic                  halted_o;
  logic [DATA_WIDTH-1:0] fetch_count_o;

  // Debug visibility: FSM state (0=BOOT, 1=RUN, 2=HALT) and pending-redirect flag.
  logic [1:0]            state_o;
  logic                  pend_vld_o;

  // Requests are levels sampled every cycle; there is no ready/backpressure.
  // Outputs respond combinationally in the same cycle the request is seen.
  modport master (
    output stall_req_i, redirect_i, redirect_addr_i, halt_i,
    input  pc_en_o, PCSrc_o, branch_target_addr_o, IF_ID_write_o, IF_ID_flush_o,
           ID_EX_flush_o, fetch_valid_o, halted_o, fetch_count_o, state_o, pend_vld_o
  );

  modport slave (
    input  stall_req_i, redirect_i, redirect_addr_i, halt_i,
    output pc_en_o, PCSrc_o, branch_target_addr_o, IF_ID_write_o, IF_ID_flush_o,
           ID_EX_flush_o, fetch_valid_o, halted_o, fetch_count_o, state_o, pend_vld_o
  );
endinterface

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: boot hold, redirects, load-use stalls and halt with
// a held redirect that is replayed when the halt releases.
module fetch_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int BOOT_DELAY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int CW = (BOOT_DELAY > 2) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);
  localparam state_e RESET_STATE = (BOOT_DELAY == 0) ? ST_RUN : ST_BOOT;

  state_e                state_q, state_d;
  logic [CW-1:0]         boot_cnt_q, boot_cnt_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic                  pc_en;
  logic                  pc_src;
  logic [DATA_WIDTH-1:0] target;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  fetch_valid;
  logic                  run_cyc;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    target      = '0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    run_cyc     = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      ST_RUN: run_cyc = 1'b1;
      ST_HALT: begin
        if (bus.halt_i) begin
          // Held redirects flush the pipe now; only the latest target is kept.
          if (bus.redirect_i) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pend_vld_d  = 1'b1;
            pend_addr_d = bus.redirect_addr_i;
          end
        end else begin
          // Release cycle behaves exactly like RUN without a halt request.
          state_d = ST_RUN;
          run_cyc = 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    if (run_cyc) begin
      if (bus.redirect_i) begin
        pc_en       = 1'b1;
        pc_src      = 1'b1;
        target      = bus.redirect_addr_i;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        pend_vld_d  = 1'b0;
        if (bus.halt_i) state_d = ST_HALT;
      end else if (bus.halt_i) begin
        state_d = ST_HALT;
      end else if (pend_vld_q) begin
        pc_en       = 1'b1;
        pc_src      = 1'b1;
        target      = pend_addr_q;
        if_id_flush = 1'b1;
        pend_vld_d  = 1'b0;
      end else if (bus.stall_req_i) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_write = 1'b1;
      end
    end

    fetch_valid   = pc_en & if_id_write & ~if_id_flush;
    fetch_count_d = fetch_count_q;
    if (fetch_valid) fetch_count_d = fetch_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      boot_cnt_q    <= '0;
      pend_vld_q    <= 1'b0;
      pend_addr_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pend_vld_q    <= pend_vld_d;
      pend_addr_q   <= pend_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.pc_en_o              = pc_en;
  assign bus.PCSrc_o              = pc_src;
  assign bus.branch_target_addr_o = target;
  assign bus.IF_ID_write_o        = if_id_write;
  assign bus.IF_ID_flush_o        = if_id_flush;
  assign bus.ID_EX_flush_o        = id_ex_flush;
  assign bus.fetch_valid_o        = fetch_valid;
  assign bus.halted_o             = (state_q == ST_HALT);
  assign bus.fetch_count_o        = fetch_count_q;
  assign bus.state_o              = state_q;
  assign bus.pend_vld_o           = pend_vld_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a 32-bit instance with a 4-cycle boot
// and an 8-bit instance with no boot hold for the fetch-counter wrap.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic rst8_n;

  always #5 clk = ~clk;

  fetch_controller_if #(.DATA_WIDTH(32)) bus ();
  fetch_controller_if #(.DATA_WIDTH(8))  bus8 ();

  fetch_controller #(.DATA_WIDTH(32), .BOOT_DELAY(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  fetch_controller #(.DATA_WIDTH(8), .BOOT_DELAY(0)) dut8 (
    .clk(clk), .rst_n(rst8_n), .bus(bus8)
  );

  // {pc_en, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush, fetch_valid, halted}
  logic [6:0] ctl, ctl8;
  assign ctl  = {bus.pc_en_o, bus.PCSrc_o, bus.IF_ID_write_o, bus.IF_ID_flush_o,
                 bus.ID_EX_flush_o, bus.fetch_valid_o, bus.halted_o};
  assign ctl8 = {bus8.pc_en_o, bus8.PCSrc_o, bus8.IF_ID_write_o, bus8.IF_ID_flush_o,
                 bus8.ID_EX_flush_o, bus8.fetch_valid_o, bus8.halted_o};

  localparam logic [6:0] V_BOOT       = 7'b0001100;
  localparam logic [6:0] V_FETCH      = 7'b1010010;
  localparam logic [6:0] V_STALL      = 7'b0000100;
  localparam logic [6:0] V_REDIR      = 7'b1101100;
  localparam logic [6:0] V_HOLD       = 7'b0000000;
  localparam logic [6:0] V_HALT       = 7'b0000001;
  localparam logic [6:0] V_HALT_REDIR = 7'b0001101;
  localparam logic [6:0] V_REPLAY     = 7'b1101001;
  localparam logic [6:0] V_REL_FETCH  = 7'b1010011;
  localparam logic [6:0] V_REL_REDIR  = 7'b1101101;
  localparam logic [6:0] V_REL_STALL  = 7'b0000101;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = 32'd0;

  // ---------------- clock/reset helpers and driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] a, input logic hl);
    bus.stall_req_i     = st;
    bus.redirect_i      = rd;
    bus.redirect_addr_i = a;
    bus.halt_i          = hl;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'hdead_beef, 1'b1);
    n_checks++; if (ctl !== V_BOOT) $display("FAIL reset_ctl got=%b exp=%b", ctl, V_BOOT); else n_pass++;
    n_checks++; if (bus.state_o !== 2'd0) $display("FAIL reset_state got=%0d exp=0", bus.state_o); else n_pass++;
    n_checks++; if (bus.fetch_count_o !== 32'd0) $display("FAIL reset_count got=%0d exp=0", bus.fetch_count_o); else n_pass++;
    n_checks++; if (bus.branch_target_addr_o !== 32'd0) $display("FAIL reset_target got=%h exp=0", bus.branch_target_addr_o); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ctl !== V_BOOT) $display("FAIL boot_ctl[%0d] got=%b exp=%b", i, ctl, V_BOOT); else n_pass++;
      n_checks++; if (bus.branch_target_addr_o !== 32'd0) $display("FAIL boot_target[%0d] got=%h exp=0", i, bus.branch_target_addr_o); else n_pass++;
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (ctl !== V_FETCH) $display("FAIL boot_first_run got=%b exp=%b", ctl, V_FETCH); else n_pass++;
    n_checks++; if (bus.pend_vld_o !== 1'b0) $display("FAIL boot_no_pend got=%b exp=0", bus.pend_vld_o); else n_pass++;
    tick();
    exp_cnt = 32'd1;
    n_checks++; if (bus.fetch_count_o !== exp_cnt) $display("FAIL boot_count got=%0d exp=%0d", bus.fetch_count_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (ctl !== V_FETCH) $display("FAIL stall_pre got=%b exp=%b", ctl, V_FETCH); else n_pass++;
    tick(); exp_cnt++;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      n_checks++; if (ctl !== V_STALL) $display("FAIL stall_ctl[%0d] got=%b exp=%b", i, ctl, V_STALL); else n_pass++;
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (ctl !== V_FETCH) $display("FAIL stall_post got=%b exp=%b", ctl, V_FETCH); else n_pass++;
    n_checks++; if (bus.fetch_count_o !== exp_cnt) $display("FAIL stall_count got=%0d exp=%0d", bus.fetch_count_o, exp_cnt); else n_pass++;
    tick(); exp_cnt++;
  endtask

  task automatic test_redirect_vs_stall();
    drive(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    n_checks++; if (ctl !== V_REDIR) $display("FAIL rvs_ctl got=%b exp=%b", ctl, V_REDIR); else n_pass++;
    n_checks++; if (bus.branch_target_addr_o !== 32'h100) $display("FAIL rvs_target got=%h exp=100", bus.branch_target_addr_o); else n_pass++;
    tick();
    drive(1'b0, 1'b1, 32'h0000_0180, 1'b0);
    n_checks++; if (ctl !== V_REDIR) $display("FAIL b2b_ctl got=%b exp=%b", ctl, V_REDIR); else n_pass++;
    n_checks++; if (bus.branch_target_addr_o !== 32'h180) $display("FAIL b2b_target got=%h exp=180", bus.branch_target_addr_o); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (ctl !== V_FETCH) $display("FAIL rvs_post got=%b exp=%b", ctl, V_FETCH); else n_pass++;
    n_checks++; if (bus.fetch_count_o !== exp_cnt) $display("FAIL rvs_count got=%0d exp=%0d", bus.fetch_count_o, exp_cnt); else n_pass++;
    tick(); exp_cnt++;
  endtask

  task automatic test_halt_replay();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ctl !== V_HOLD) $display("FAIL hr_enter got=%b exp=%b", ctl, V_HOLD); else n_pass++;
    tick();
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    n_checks++; if (ctl !== V_HALT_REDIR) $display("FAIL hr_redir1 got=%b exp=%b", ctl, V_HALT_REDIR); else n_pass++;
    n_checks++; if (bus.branch_target_addr_o !== 32'h0) $display("FAIL hr_target_held got=%h exp=0", bus.branch_target_addr_o); else n_pass++;
    tick();
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    n_checks++; if (ctl !== V_HALT_REDIR) $display("FAIL hr_redir2 got=%b exp=%b", ctl, V_HALT_REDIR); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ctl !== V_HALT) $display("FAIL hr_idle got=%b exp=%b", ctl, V_HALT); else n_pass++;
    n_checks++; if (bus.pend_vld_o !== 1'b1) $display("FAIL hr_pend_set got=%b exp=1", bus.pend_vld_o); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (ctl !== V_REPLAY) $display("FAIL hr_replay got=%b exp=%b", ctl, V_REPLAY); else n_pass++;
    n_checks++; if (bus.branch_target_addr_o !== 32'h300) $display("FAIL hr_replay_target got=%h exp=300", bus.branch_target_addr_o); else n_pass++;
    tick();
    n_checks++; if (ctl !== V_FETCH) $display("FAIL hr_after got=%b exp=%b", ctl, V_FETCH); else n_pass++;
    n_checks++; if (bus.pend_vld_o !== 1'b0) $display("FAIL hr_pend_clr got=%b exp=0", bus.pend_vld_o); else n_pass++;
    n_checks++; if (bus.fetch_count_o !== exp_cnt) $display("FAIL hr_count got=%0d exp=%0d", bus.fetch_count_o, exp_cnt); else n_pass++;
    tick(); exp_cnt++;
  endtask

  task automatic test_halt_variants();
    // Redirect together with halt in RUN is applied immediately, not pended.
    drive(1'b0, 1'b1, 32'h0000_0440, 1'b1);
    n_checks++; if (ctl !== V_REDIR) $display("FAIL hv_redir_halt got=%b exp=%b", ctl, V_REDIR); else n_pass++;
    n_checks++; if (bus.branch_target_addr_o !== 32'h440) $display("FAIL hv_redir_target got=%h exp=440", bus.branch_target_addr_o); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (ctl !== V_REL_FETCH) $display("FAIL hv_rel_nopend got=%b exp=%b", ctl, V_REL_FETCH); else n_pass++;
    tick(); exp_cnt++;
    // Live redirect on release overrides the pend.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0500, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0600, 1'b0);
    n_checks++; if (ctl !== V_REL_REDIR) $display("FAIL hv_rel_redir got=%b exp=%b", ctl, V_REL_REDIR); else n_pass++;
    n_checks++; if (bus.branch_target_addr_o !== 32'h600) $display("FAIL hv_rel_target got=%h exp=600", bus.branch_target_addr_o); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (ctl !== V_FETCH) $display("FAIL hv_no_stale got=%b exp=%b", ctl, V_FETCH); else n_pass++;
    n_checks++; if (bus.pend_vld_o !== 1'b0) $display("FAIL hv_pend_clr got=%b exp=0", bus.pend_vld_o); else n_pass++;
    tick(); exp_cnt++;
    // Stall on the release cycle with nothing pending.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++; if (ctl !== V_REL_STALL) $display("FAIL hv_rel_stall got=%b exp=%b", ctl, V_REL_STALL); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (bus.fetch_count_o !== exp_cnt) $display("FAIL hv_count got=%0d exp=%0d", bus.fetch_count_o, exp_cnt); else n_pass++;
    tick(); exp_cnt++;
  endtask

  task automatic test_reset_mid_halt();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (bus.pend_vld_o !== 1'b1) $display("FAIL rmh_pend_set got=%b exp=1", bus.pend_vld_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.state_o !== 2'd0) $display("FAIL rmh_state got=%0d exp=0", bus.state_o); else n_pass++;
    n_checks++; if (bus.pend_vld_o !== 1'b0) $display("FAIL rmh_pend_clr got=%b exp=0", bus.pend_vld_o); else n_pass++;
    n_checks++; if (bus.fetch_count_o !== 32'd0) $display("FAIL rmh_count got=%0d exp=0", bus.fetch_count_o); else n_pass++;
    n_checks++; if (ctl !== V_BOOT) $display("FAIL rmh_ctl got=%b exp=%b", ctl, V_BOOT); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ctl !== V_BOOT) $display("FAIL rmh_boot[%0d] got=%b exp=%b", i, ctl, V_BOOT); else n_pass++;
      tick();
    end
    n_checks++; if (ctl !== V_FETCH) $display("FAIL rmh_no_replay got=%b exp=%b", ctl, V_FETCH); else n_pass++;
    n_checks++; if (bus.branch_target_addr_o !== 32'h0) $display("FAIL rmh_target got=%h exp=0", bus.branch_target_addr_o); else n_pass++;
    tick();
    exp_cnt = 32'd1;
    n_checks++; if (bus.fetch_count_o !== exp_cnt) $display("FAIL rmh_count_after got=%0d exp=%0d", bus.fetch_count_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    n_checks++; if (ctl8 !== V_FETCH) $display("FAIL wrap_reset_run got=%b exp=%b", ctl8, V_FETCH); else n_pass++;
    n_checks++; if (bus8.state_o !== 2'd1) $display("FAIL wrap_reset_state got=%0d exp=1", bus8.state_o); else n_pass++;
    n_checks++; if (bus8.fetch_count_o !== 8'd0) $display("FAIL wrap_reset_count got=%0d exp=0", bus8.fetch_count_o); else n_pass++;
    rst8_n = 1'b1;
    repeat (255) tick();
    n_checks++; if (bus8.fetch_count_o !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", bus8.fetch_count_o); else n_pass++;
    tick();
    n_checks++; if (bus8.fetch_count_o !== 8'd0) $display("FAIL wrap_256 got=%0d exp=0", bus8.fetch_count_o); else n_pass++;
    tick();
    n_checks++; if (bus8.fetch_count_o !== 8'd1) $display("FAIL wrap_257 got=%0d exp=1", bus8.fetch_count_o); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst8_n               = 1'b0;
    bus8.stall_req_i     = 1'b0;
    bus8.redirect_i      = 1'b0;
    bus8.redirect_addr_i = 8'h0;
    bus8.halt_i          = 1'b0;
    test_reset();
    test_stall();
    test_redirect_vs_stall();
    test_halt_replay();
    test_halt_variants();
    test_reset_mid_halt();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
